bram_portb_arbiter: RTL and testbench

//  Shares the otherwise-idle native port B of the dual-port weight/activation BRAM between two
//  on-chip requesters (m0: layer engine, m1: result writeback / DMA). Port A stays with the
//  AXI BRAM controller.
//  - Round-robin arbitration, one access per cycle.
//  - Optional per-requester lock for back-to-back bursts.
//  - Read data is routed back to the requester that issued the read.

---
 rtl/bram_portb_arbiter.sv | 118 +++++++++++
 tb/tb_bram_portb_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bram_portb_arbiter.sv
// bram_portb_arbiter: round-robin arbiter sharing BRAM port B between two requesters
//
// Ports:
//   s_axi_aclk, s_axi_aresetn         clock and asynchronous active-low reset
//   mN_req_valid/ready/we/lock/addr/wdata  request channel of requester N (N = 0, 1)
//   mN_rsp_valid/data                 one-cycle read-data strobe back to requester N
//   bram_en_b/we_b/addr_b/wrdata_b    registered port-B command
//   bram_rddata_b                     port-B read data, valid RD_LATENCY cycles after bram_en_b
module bram_portb_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 16
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic              m0_req_lock,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_data,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic              m1_req_lock,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_data,
  output logic              bram_en_b,
  output logic              bram_we_b,
  output logic [ADDR_W-1:0] bram_addr_b,
  output logic [DATA_W-1:0] bram_wrdata_b,
  input  logic [DATA_W-1:0] bram_rddata_b
);
  localparam int D  = 1 + RD_LATENCY;
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LIM = CW'(MAX_LOCK - 1);
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
  state_t              r_state, w_state_nx;
  logic                r_last, w_last_nx;
  logic [CW-1:0]       r_lock_cnt, w_lock_cnt_nx;
  logic                w_g0, w_g1, w_acc, w_id, w_we, w_lock;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                r_en, r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [D-1:0]        r_pv, r_pid;
  // Grants are held off while reset is asserted so every output reads 0 in reset.
  assign w_g0 = s_axi_aresetn & m0_req_valid &
                ((r_state == LOCK0) | ((r_state == ARB) & (!m1_req_valid | r_last)));
  assign w_g1 = s_axi_aresetn & m1_req_valid &
                ((r_state == LOCK1) | ((r_state == ARB) & (!m0_req_valid | !r_last)));
  assign w_acc   = w_g0 | w_g1;
  assign w_id    = w_g1;
  assign w_we    = w_id ? m1_req_we    : m0_req_we;
  assign w_lock  = w_id ? m1_req_lock  : m0_req_lock;
  assign w_addr  = w_id ? m1_req_addr  : m0_req_addr;
  assign w_wdata = w_id ? m1_req_wdata : m0_req_wdata;
  assign m0_req_ready = w_g0;
  assign m1_req_ready = w_g1;
  always_comb begin
    w_state_nx    = r_state;
    w_lock_cnt_nx = r_lock_cnt;
    w_last_nx     = r_last;
    if (w_acc) begin
      if (r_state == ARB) begin
        w_last_nx     = w_id;
        w_state_nx    = (w_lock && MAX_LOCK > 1) ? (w_id ? LOCK1 : LOCK0) : ARB;
        w_lock_cnt_nx = (w_lock && MAX_LOCK > 1) ? CW'(1) : '0;
      end else if (w_lock && r_lock_cnt < LIM) begin
        w_lock_cnt_nx = r_lock_cnt + CW'(1);
      end else begin
        // lock dropped, or this beat reaches MAX_LOCK: forced release
        w_state_nx    = ARB;
        w_lock_cnt_nx = '0;
      end
    end
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state    <= ARB;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_pv       <= '0;
      r_pid      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_last     <= w_last_nx;
      r_lock_cnt <= w_lock_cnt_nx;
      r_en       <= w_acc;
      r_we       <= w_acc & w_we;
      if (w_acc) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      // stage k is visible k+1 cycles after accept; last stage lines up with bram_rddata_b
      r_pv  <= {r_pv[D-2:0], w_acc & !w_we};
      r_pid <= {r_pid[D-2:0], w_id};
    end
  end
  assign bram_en_b     = r_en;
  assign bram_we_b     = r_we;
  assign bram_addr_b   = r_addr;
  assign bram_wrdata_b = r_wdata;
  assign m0_rsp_valid  = r_pv[D-1] & !r_pid[D-1];
  assign m1_rsp_valid  = r_pv[D-1] &  r_pid[D-1];
  assign m0_rsp_data   = m0_rsp_valid ? bram_rddata_b : '0;
  assign m1_rsp_data   = m1_rsp_valid ? bram_rddata_b : '0;
endmodule

// File: tb/tb_bram_portb_arbiter.sv
// tb_bram_portb_arbiter: directed self-checking bench for bram_portb_arbiter
module tb_bram_portb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_req_lock, m0_rsp_valid;
  logic [9:0]  m0_req_addr;
  logic [31:0] m0_req_wdata, m0_rsp_data;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_req_lock, m1_rsp_valid;
  logic [9:0]  m1_req_addr;
  logic [31:0] m1_req_wdata, m1_rsp_data;
  logic        bram_en_b, bram_we_b;
  logic [9:0]  bram_addr_b;
  logic [31:0] bram_wrdata_b, bram_rddata_b;
  int total = 0;
  int bad   = 0;
  always #5 clk = ~clk;
  bram_portb_arbiter dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_lock(m0_req_lock), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_lock(m1_req_lock), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
    .bram_en_b(bram_en_b), .bram_we_b(bram_we_b), .bram_addr_b(bram_addr_b),
    .bram_wrdata_b(bram_wrdata_b), .bram_rddata_b(bram_rddata_b)
  );
  // 1024x32 read-first block memory; unwritten words read as 0xA000_0000 | addr
  logic [31:0] mem [1024];
  bit          wr_v [1024];
  always @(posedge clk) begin
    if (bram_en_b) begin
      bram_rddata_b <= wr_v[bram_addr_b] ? mem[bram_addr_b] : {22'h280000, bram_addr_b};
      if (bram_we_b) begin
        mem[bram_addr_b]  <= bram_wrdata_b;
        wr_v[bram_addr_b] <= 1'b1;
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // every cycle out of reset: exclusive grants, grants only to valid requesters, exclusive responses
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert (!(m0_rsp_valid && m1_rsp_valid) && !(m0_req_ready && m1_req_ready) &&
              (!m0_req_ready || m0_req_valid) && (!m1_req_ready || m1_req_valid)) else begin
        bad++;
        $error("FAIL invariant: rdy=%b%b val=%b%b rsp=%b%b", m1_req_ready, m0_req_ready,
               m1_req_valid, m0_req_valid, m1_rsp_valid, m0_rsp_valid);
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_lock = 1'b0; m0_req_addr = 10'h010; m0_req_wdata = '0;
    m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_lock = 1'b0; m1_req_addr = 10'h020; m1_req_wdata = '0;
    // reset held 5 cycles with both valids high
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("rst_ready", {m1_req_ready, m0_req_ready}, 2'b00);
      chk("rst_bram_en_we", {bram_en_b, bram_we_b}, 2'b00);
      chk("rst_bram_addr", bram_addr_b, 10'h000);
      chk("rst_bram_wrdata", bram_wrdata_b, 32'h0);
      chk("rst_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
      chk("rst_rsp_data", {m1_rsp_data, m0_rsp_data}, 64'h0);
    end
    tick(); rst_n = 1'b1; #1;
    chk("first_grant_m0", {m1_req_ready, m0_req_ready}, 2'b01);
    chk("first_cycle_en", bram_en_b, 1'b0);
    // contention: alternating grants, responses two cycles after accept
    tick(); #1;
    chk("cont_grant_m1", {m1_req_ready, m0_req_ready}, 2'b10);
    chk("cont_issue0_en", {bram_en_b, bram_we_b}, 2'b10);
    chk("cont_issue0_addr", bram_addr_b, 10'h010);
    chk("cont_rsp_none", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    tick(); #1;
    chk("cont_grant_m0b", {m1_req_ready, m0_req_ready}, 2'b01);
    chk("cont_issue1_addr", bram_addr_b, 10'h020);
    chk("cont_rsp0_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b01);
    chk("cont_rsp0_data", m0_rsp_data, 32'hA000_0010);
    tick(); #1;
    chk("cont_grant_m1b", {m1_req_ready, m0_req_ready}, 2'b10);
    chk("cont_issue2_addr", bram_addr_b, 10'h010);
    chk("cont_rsp1_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b10);
    chk("cont_rsp1_data", m1_rsp_data, 32'hA000_0020);
    tick(); m0_req_valid = 1'b0; m1_req_valid = 1'b0; #1;
    chk("cont_issue3", {bram_en_b, bram_addr_b}, {1'b1, 10'h020});
    chk("cont_rsp0b", {m1_rsp_valid, m0_rsp_valid, m0_rsp_data}, {2'b01, 32'hA000_0010});
    tick(); #1;
    chk("cont_idle_en", {bram_en_b, bram_we_b}, 2'b00);
    chk("cont_rsp1b", {m1_rsp_valid, m0_rsp_valid, m1_rsp_data}, {2'b10, 32'hA000_0020});
    tick(); #1;
    chk("cont_drained", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    // write by m1 to the top address, then read back by m0
    m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 10'h3FF; m1_req_wdata = 32'hCAFE_0001; #1;
    chk("wr_grant_m1", {m1_req_ready, m0_req_ready}, 2'b10);
    tick(); m1_req_valid = 1'b0; m1_req_we = 1'b0; m0_req_valid = 1'b1; m0_req_addr = 10'h3FF; #1;
    chk("rd_grant_m0", {m1_req_ready, m0_req_ready}, 2'b01);
    chk("wr_issue", {bram_en_b, bram_we_b, bram_addr_b, bram_wrdata_b}, {2'b11, 10'h3FF, 32'hCAFE_0001});
    tick(); m0_req_valid = 1'b0; #1;
    chk("rd_issue", {bram_en_b, bram_we_b, bram_addr_b}, {2'b10, 10'h3FF});
    chk("wr_no_rsp", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    tick(); #1;
    chk("raw_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b01);
    chk("raw_rsp_data", m0_rsp_data, 32'hCAFE_0001);
    tick();
    // lock: m0 holds the port for MAX_LOCK beats while m1 waits
    m0_req_valid = 1'b1; m0_req_lock = 1'b1; m0_req_addr = 10'h100; #1;
    chk("lock_beat1", {m1_req_ready, m0_req_ready}, 2'b01);
    m1_req_addr = 10'h200;
    for (int i = 1; i < 16; i++) begin
      tick(); m1_req_valid = 1'b1; m0_req_addr = 10'h100 + 10'(i); #1;
      chk($sformatf("lock_beat%0d", i + 1), {m1_req_ready, m0_req_ready}, 2'b01);
    end
    tick(); m0_req_addr = 10'h110; #1;
    chk("lock_forced_release_m1", {m1_req_ready, m0_req_ready}, 2'b10);
    tick(); m1_req_valid = 1'b0; #1;
    chk("lock_m0_resume", {m1_req_ready, m0_req_ready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("lock_m0_tail", {m1_req_ready, m0_req_ready}, 2'b01);
    end
    tick(); m0_req_valid = 1'b0; m1_req_valid = 1'b1; #1;
    chk("lock_held_while_idle", {m1_req_ready, m0_req_ready}, 2'b00);
    // lock release: remaining burst lock=1,1,0 then m1 wins the tie
    tick(); m0_req_valid = 1'b1; #1;
    chk("rel_beat1", {m1_req_ready, m0_req_ready}, 2'b01);
    tick(); #1;
    chk("rel_beat2", {m1_req_ready, m0_req_ready}, 2'b01);
    tick(); m0_req_lock = 1'b0; #1;
    chk("rel_beat3", {m1_req_ready, m0_req_ready}, 2'b01);
    tick(); #1;
    chk("rel_grant_m1", {m1_req_ready, m0_req_ready}, 2'b10);
    tick(); m0_req_valid = 1'b0; m1_req_valid = 1'b0; #1;
    tick(); #1;
    chk("rel_rsp1", {m1_rsp_valid, m0_rsp_valid, m1_rsp_data}, {2'b10, 32'hA000_0200});
    for (int i = 0; i < 3; i++) tick();
    // reset one cycle after a read is accepted
    m0_req_valid = 1'b1; m0_req_addr = 10'h055; #1;
    chk("midrst_accept", {m1_req_ready, m0_req_ready}, 2'b01);
    tick(); m0_req_valid = 1'b0; rst_n = 1'b0; #1;
    chk("midrst_en_suppressed", {bram_en_b, bram_addr_b}, {1'b0, 10'h000});
    chk("midrst_rsp_in_rst", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    tick(); rst_n = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_rsp", {m1_rsp_valid, m0_rsp_valid, bram_en_b}, 3'b000);
      tick(); #1;
    end
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; #1;
    chk("midrst_m0_first", {m1_req_ready, m0_req_ready}, 2'b01);
    tick();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
